// File: rtl/fir_coef_loader.sv
// -----------------------------------------------------------------------------
// fir_coef_loader
//
// Host-side sequencer that turns a byte stream (LSB then MSB per tap) into
// write transactions on the FIR filter bank's coefficient port. While a
// filter's coefficients are being replaced, audio_hold asks the audio path to
// pause.
//
// Sequence per load:
//   IDLE -> ADDR_RST (clear bank write address) -> ADDR_CHK (confirm it is 0)
//        -> { GET_LSB -> GET_MSB -> WRITE -> SETTLE } x num_taps -> FINISH
//
// Ports
//   clk, reset_n        system clock, synchronous active-low reset
//   start               1-clk pulse, begin a load (only accepted in IDLE)
//   filter_sel[3:0]     target filter RAM, latched on accepted start
//   num_taps[7:0]       coefficient count, latched on accepted start
//   abort               cancel an in-progress load
//   byte_valid          byte_data valid
//   byte_data[7:0]      coefficient byte, LSB first then MSB
//   byte_ready          byte accepted this clk when byte_valid is also high
//   coef_addr_rst       1-clk pulse clearing the bank write address
//   coefficient_wr_en   1-clk write strobe, one per tap
//   coef_select[3:0]    RAM select (latched filter_sel)
//   coef_wr_lsb_data    coefficient bits [7:0]
//   coef_wr_msb_data    coefficient bits [15:8]
//   wr_addr_zero        bank reports its write address is 0
//   busy                load in progress
//   audio_hold          request audio pause; drops 1 clk after done/abort
//   done                1-clk pulse at end of a load (success or error)
//   error               sticky fault flag, cleared by the next accepted start
//   taps_loaded[7:0]    taps written in the current/last load
//
// Every output is a flop. Output flops are loaded from the next-state value,
// so each output tracks the state it describes without a decode delay.
// -----------------------------------------------------------------------------
module fir_coef_loader #(
  parameter int NUM_FILTERS = 4,
  parameter int MAX_TAPS    = 255,
  parameter int SETTLE_CLKS = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] filter_sel,
  input  logic [7:0] num_taps,
  input  logic       abort,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       coef_addr_rst,
  output logic       coefficient_wr_en,
  output logic [3:0] coef_select,
  output logic [7:0] coef_wr_lsb_data,
  output logic [7:0] coef_wr_msb_data,
  input  logic       wr_addr_zero,
  output logic       busy,
  output logic       audio_hold,
  output logic       done,
  output logic       error,
  output logic [7:0] taps_loaded
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR_RST = 3'd1,
    ADDR_CHK = 3'd2,
    GET_LSB  = 3'd3,
    GET_MSB  = 3'd4,
    WRITE    = 3'd5,
    SETTLE   = 3'd6,
    FINISH   = 3'd7
  } state_t;

  // Comparisons are widened by one bit so the limits stay representable.
  localparam logic [4:0] NUM_FILTERS_C = 5'(NUM_FILTERS);
  localparam logic [8:0] MAX_TAPS_C    = 9'(MAX_TAPS);
  localparam logic [7:0] SETTLE_LAST_C = 8'(SETTLE_CLKS - 1);

  state_t     state_r, next_state_s;

  // Latched load parameters and datapath
  logic [3:0] sel_r, sel_next_s;
  logic [7:0] taps_r, taps_next_s;
  logic [7:0] cnt_r, cnt_next_s;          // ADDR_CHK wait and SETTLE timer
  logic [7:0] lsb_r, lsb_next_s;
  logic [7:0] msb_r, msb_next_s;
  logic [7:0] loaded_r, loaded_next_s;
  logic       error_r, error_next_s;

  // Output flops
  logic       busy_r;
  logic       audio_hold_r;
  logic       done_r;
  logic       wr_en_r;
  logic       addr_rst_r;
  logic       byte_ready_r;

  logic       transfer_s;
  logic       params_bad_s;
  logic       next_busy_s;

  assign transfer_s   = byte_valid & byte_ready_r;
  assign params_bad_s = ({1'b0, filter_sel} >= NUM_FILTERS_C) ||
                        (num_taps == 8'd0) ||
                        ({1'b0, num_taps} > MAX_TAPS_C);
  assign next_busy_s  = (next_state_s != IDLE) && (next_state_s != FINISH);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and datapath next-value logic
  always_comb begin
    next_state_s  = state_r;
    sel_next_s    = sel_r;
    taps_next_s   = taps_r;
    cnt_next_s    = cnt_r;
    lsb_next_s    = lsb_r;
    msb_next_s    = msb_r;
    loaded_next_s = loaded_r;
    error_next_s  = error_r;

    case (state_r)
      IDLE: begin
        if (start) begin
          sel_next_s    = filter_sel;
          taps_next_s   = num_taps;
          loaded_next_s = 8'd0;
          if (params_bad_s) begin
            error_next_s = 1'b1;
            next_state_s = FINISH;
          end else begin
            error_next_s = 1'b0;
            next_state_s = ADDR_RST;
          end
        end else begin
          next_state_s = IDLE;
        end
      end

      ADDR_RST: begin
        cnt_next_s   = 8'd0;
        next_state_s = ADDR_CHK;
      end

      // First clk lets the bank react to coef_addr_rst; second clk samples.
      ADDR_CHK: begin
        if (cnt_r == 8'd0) begin
          cnt_next_s = 8'd1;
        end else if (wr_addr_zero) begin
          next_state_s = GET_LSB;
        end else begin
          error_next_s = 1'b1;
          next_state_s = FINISH;
        end
      end

      GET_LSB: begin
        if (transfer_s) begin
          lsb_next_s   = byte_data;
          next_state_s = GET_MSB;
        end else begin
          next_state_s = GET_LSB;
        end
      end

      // taps_loaded steps on the same edge the write strobe rises.
      GET_MSB: begin
        if (transfer_s) begin
          msb_next_s    = byte_data;
          loaded_next_s = loaded_r + 8'd1;
          next_state_s  = WRITE;
        end else begin
          next_state_s = GET_MSB;
        end
      end

      WRITE: begin
        cnt_next_s   = 8'd0;
        next_state_s = SETTLE;
      end

      SETTLE: begin
        if (cnt_r == SETTLE_LAST_C) begin
          if (loaded_r == taps_r) begin
            next_state_s = FINISH;
          end else begin
            next_state_s = GET_LSB;
          end
        end else begin
          cnt_next_s = cnt_r + 8'd1;
        end
      end

      FINISH: begin
        next_state_s = IDLE;
      end

      default: begin
        next_state_s = IDLE;
      end
    endcase

    // Abort wins over everything while busy; a tap whose MSB arrives in the
    // same clk is not counted because its strobe will never be issued.
    if (abort && busy_r) begin
      next_state_s  = IDLE;
      error_next_s  = 1'b1;
      loaded_next_s = loaded_r;
    end else begin
      next_state_s  = next_state_s;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_r    <= 4'd0;
      taps_r   <= 8'd0;
      cnt_r    <= 8'd0;
      lsb_r    <= 8'd0;
      msb_r    <= 8'd0;
      loaded_r <= 8'd0;
      error_r  <= 1'b0;
    end else begin
      sel_r    <= sel_next_s;
      taps_r   <= taps_next_s;
      cnt_r    <= cnt_next_s;
      lsb_r    <= lsb_next_s;
      msb_r    <= msb_next_s;
      loaded_r <= loaded_next_s;
      error_r  <= error_next_s;
    end
  end

  // Output flops loaded from the next state; audio_hold stays up one extra
  // clk after busy falls so the audio path restarts after the last strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_r       <= 1'b0;
      audio_hold_r <= 1'b0;
      done_r       <= 1'b0;
      wr_en_r      <= 1'b0;
      addr_rst_r   <= 1'b0;
      byte_ready_r <= 1'b0;
    end else begin
      busy_r       <= next_busy_s;
      audio_hold_r <= (next_state_s != IDLE) || busy_r;
      done_r       <= (next_state_s == FINISH);
      wr_en_r      <= (next_state_s == WRITE);
      addr_rst_r   <= (next_state_s == ADDR_RST);
      byte_ready_r <= (next_state_s == GET_LSB) || (next_state_s == GET_MSB);
    end
  end

  assign byte_ready        = byte_ready_r;
  assign coef_addr_rst     = addr_rst_r;
  assign coefficient_wr_en = wr_en_r;
  assign coef_select       = sel_r;
  assign coef_wr_lsb_data  = lsb_r;
  assign coef_wr_msb_data  = msb_r;
  assign busy              = busy_r;
  assign audio_hold        = audio_hold_r;
  assign done              = done_r;
  assign error             = error_r;
  assign taps_loaded       = loaded_r;

endmodule

// File: tb/tb_fir_coef_loader.sv
// -----------------------------------------------------------------------------
// tb_fir_coef_loader
//
// Directed bench for fir_coef_loader. Expected coefficient writes are pushed
// to a scoreboard queue as bytes are planned and popped by a monitor on each
// write strobe. A small bank model clears its write address on coef_addr_rst
// and advances it on each strobe to produce wr_addr_zero.
// -----------------------------------------------------------------------------
module tb_fir_coef_loader;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] filter_sel = 4'd0;
  logic [7:0] num_taps = 8'd0;
  logic       abort = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'd0;
  logic       byte_ready;
  logic       coef_addr_rst;
  logic       coefficient_wr_en;
  logic [3:0] coef_select;
  logic [7:0] coef_wr_lsb_data;
  logic [7:0] coef_wr_msb_data;
  logic       wr_addr_zero;
  logic       busy;
  logic       audio_hold;
  logic       done;
  logic       error;
  logic [7:0] taps_loaded;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [19:0] exp_q[$];
  int cyc = 0;
  int wr_cnt = 0;
  int rst_cnt = 0;
  int done_cnt = 0;
  int ready_cnt = 0;
  int last_wr = -1;

  logic       bank_en = 1'b1;
  logic [7:0] bank_addr = 8'd7;

  fir_coef_loader #(
    .NUM_FILTERS(4),
    .MAX_TAPS(255),
    .SETTLE_CLKS(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .filter_sel(filter_sel),
    .num_taps(num_taps),
    .abort(abort),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .coef_addr_rst(coef_addr_rst),
    .coefficient_wr_en(coefficient_wr_en),
    .coef_select(coef_select),
    .coef_wr_lsb_data(coef_wr_lsb_data),
    .coef_wr_msb_data(coef_wr_msb_data),
    .wr_addr_zero(wr_addr_zero),
    .busy(busy),
    .audio_hold(audio_hold),
    .done(done),
    .error(error),
    .taps_loaded(taps_loaded)
  );

  always #5 clk = ~clk;

  // Bank write-address model
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (coef_addr_rst) bank_addr <= 8'd0;
    else if (coefficient_wr_en) bank_addr <= bank_addr + 8'd1;
  end
  assign wr_addr_zero = bank_en && (bank_addr == 8'd0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pop on each strobe, strobe spacing, event counters
  always @(negedge clk) begin
    if (coef_addr_rst) begin
      rst_cnt++;
      last_wr = -1;
    end
    if (byte_ready) ready_cnt++;
    if (done) done_cnt++;
    if (coefficient_wr_en) begin
      wr_cnt++;
      check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("wr_data", 32'({coef_select, coef_wr_msb_data, coef_wr_lsb_data}),
              32'(exp_q.pop_front()));
      end
      if (last_wr >= 0) check("strobe_gap_ge5", 32'((cyc - last_wr) >= 5), 32'd1);
      last_wr = cyc;
    end
  end

  task automatic pulse_start(input logic [3:0] sel, input logic [7:0] taps);
    start = 1'b1;
    filter_sel = sel;
    num_taps = taps;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    logic got;
    byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_data = b;
    got = 1'b0;
    n = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      if (byte_ready) got = 1'b1;
      else n++;
    end
    check("byte_accepted", 32'(got), 32'd1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  // Plans one tap: scoreboard entry, then LSB and MSB bytes.
  task automatic send_tap(input logic [3:0] sel, input logic [15:0] coef, input int gap);
    exp_q.push_back({sel, coef});
    send_byte(coef[7:0], gap);
    send_byte(coef[15:8], gap);
  endtask

  // Waits (bounded) for done; returns with the current time at the done negedge.
  task automatic wait_done(input string tag, input int max_clks);
    logic found;
    found = 1'b0;
    for (int i = 0; i < max_clks && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 32'({busy, audio_hold, done, error, byte_ready, coefficient_wr_en,
                   coef_addr_rst, coef_select, coef_wr_msb_data, coef_wr_lsb_data}), 32'd0);
    check({tag, "_taps"}, 32'(taps_loaded), 32'd0);
  endtask

  initial begin
    int w0, r0, d0, rdy0;
    logic [15:0] coef;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // T1: sel=2, 3 taps, valid held high between bytes
    w0 = wr_cnt; r0 = rst_cnt;
    pulse_start(4'd2, 8'd3);
    @(negedge clk);
    check("t1_busy_hold", 32'({busy, audio_hold}), 32'h3);
    @(posedge clk); #1;
    send_tap(4'd2, 16'h1234, 0);
    send_tap(4'd2, 16'h5678, 0);
    send_tap(4'd2, 16'h9ABC, 0);
    wait_done("t1_done", 20);
    check("t1_fin_flags", 32'({busy, audio_hold, error}), 32'h2);
    check("t1_taps", 32'(taps_loaded), 32'd3);
    check("t1_select", 32'(coef_select), 32'd2);
    @(negedge clk);
    check("t1_after", 32'({done, audio_hold}), 32'h0);
    check("t1_wr_count", 32'(wr_cnt - w0), 32'd3);
    check("t1_addr_rst", 32'(rst_cnt - r0), 32'd1);
    @(posedge clk); #1;

    // T2: invalid sel, then taps=0
    w0 = wr_cnt; r0 = rst_cnt;
    pulse_start(4'd4, 8'd5);
    wait_done("t2_sel_done", 2);
    check("t2_sel_err", 32'({error, busy}), 32'h2);
    check("t2_sel_taps", 32'(taps_loaded), 32'd0);
    @(negedge clk);
    check("t2_sel_hold_drop", 32'(audio_hold), 32'd0);
    @(posedge clk); #1;
    pulse_start(4'd1, 8'd0);
    wait_done("t2_taps_done", 2);
    check("t2_taps_err", 32'(error), 32'd1);
    @(negedge clk);
    check("t2_no_ram", 32'((wr_cnt - w0) + (rst_cnt - r0)), 32'd0);
    @(posedge clk); #1;

    // T3: bank never reports address zero
    bank_en = 1'b0;
    w0 = wr_cnt; r0 = rst_cnt; rdy0 = ready_cnt;
    pulse_start(4'd1, 8'd2);
    wait_done("t3_done", 10);
    check("t3_err", 32'(error), 32'd1);
    check("t3_addr_rst", 32'(rst_cnt - r0), 32'd1);
    check("t3_no_ready_no_wr", 32'((ready_cnt - rdy0) + (wr_cnt - w0)), 32'd0);
    bank_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // T4: abort after the first strobe of a 4-tap load
    w0 = wr_cnt; d0 = done_cnt;
    pulse_start(4'd3, 8'd4);
    send_tap(4'd3, 16'hA55A, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("t4_abort_flags", 32'({busy, error, done, audio_hold}), 32'h5);
    @(negedge clk);
    check("t4_hold_drop", 32'(audio_hold), 32'd0);
    repeat (6) @(negedge clk);
    check("t4_wr_count", 32'(wr_cnt - w0), 32'd1);
    check("t4_no_done", 32'(done_cnt - d0), 32'd0);
    check("t4_taps", 32'(taps_loaded), 32'd1);
    @(posedge clk); #1;

    // T5: random gaps, top valid filter index
    pulse_start(4'd3, 8'd5);
    for (int i = 0; i < 5; i++) begin
      coef = 16'($urandom_range(0, 65535));
      send_tap(4'd3, coef, int'($urandom_range(0, 3)));
    end
    wait_done("t5_done", 20);
    check("t5_taps_err", 32'({error, taps_loaded}), 32'h005);
    @(posedge clk); #1;

    // Single-tap boundary
    pulse_start(4'd0, 8'd1);
    send_tap(4'd0, 16'hFF01, 2);
    wait_done("t1tap_done", 20);
    check("t1tap_taps", 32'(taps_loaded), 32'd1);
    @(posedge clk); #1;

    // T6: start while busy is ignored
    w0 = wr_cnt; r0 = rst_cnt;
    pulse_start(4'd1, 8'd3);
    send_tap(4'd1, 16'h0BAD, 0);
    pulse_start(4'd2, 8'd1);
    send_tap(4'd1, 16'hC0DE, 1);
    send_tap(4'd1, 16'h7E57, 0);
    wait_done("t6_done", 20);
    check("t6_taps_err", 32'({error, taps_loaded}), 32'h003);
    check("t6_counts", 32'({8'(wr_cnt - w0), 8'(rst_cnt - r0)}), 32'h0301);
    @(posedge clk); #1;

    // T6: reset mid-load, then a clean load
    w0 = wr_cnt;
    pulse_start(4'd2, 8'd3);
    send_tap(4'd2, 16'h4321, 0);
    send_byte(8'h11, 0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midreset_no_strobe", 32'(wr_cnt - w0), 32'd1);
    @(posedge clk); #1;
    pulse_start(4'd1, 8'd2);
    send_tap(4'd1, 16'h2468, 0);
    send_tap(4'd1, 16'h1357, 1);
    wait_done("postreset_done", 20);
    check("postreset_taps_err", 32'({error, taps_loaded}), 32'h002);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
